// File: rtl/simon_pkg.sv
// Shared types for the Simon press-checking stage: direction encoding and checker states.
package simon_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_RIGHT = 2'b01;
    localparam dir_t DIR_DOWN  = 2'b10;
    localparam dir_t DIR_LEFT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PRESS,
        ST_SHIFT,
        ST_WAIT_RELEASE,
        ST_PASS,
        ST_FAIL
    } chk_state_t;

endpackage

// File: rtl/key_encoder.sv
// Combinational decode of the four debounced buttons {left,down,right,up} into a direction.
module key_encoder
    import simon_pkg::*;
(
    input  logic [3:0] key,
    output dir_t       dir,
    output logic       any_key,
    output logic       multi_key
);

    always_comb begin
        dir = DIR_UP;
        if (key[0])      dir = DIR_UP;
        else if (key[1]) dir = DIR_RIGHT;
        else if (key[2]) dir = DIR_DOWN;
        else if (key[3]) dir = DIR_LEFT;
    end

    assign any_key   = |key;
    // Clearing the lowest set bit leaves something only when two or more keys are down.
    assign multi_key = |(key & (key - 4'd1));

endmodule

// File: rtl/press_checker.sv
// Compares player presses against correct_direction and reports round pass/fail.
// Optional press timeout enabled by defining PRESS_TIMEOUT_EN.
module press_checker
    import simon_pkg::*;
#(
    parameter int SEQ_LEN = 3,
    parameter int LEN_W   = 2
`ifdef PRESS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 50000000
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] round_len,
    input  logic [3:0]       key,
    input  logic [1:0]       correct_direction,
    output logic             shift_enable,
    output logic [LEN_W-1:0] match_count,
    output logic             busy,
    output logic             round_pass,
    output logic             round_fail
);

    chk_state_t       state_q, state_d;
    logic [3:0]       key_prev_q, key_prev_d;
    logic [LEN_W-1:0] match_q, match_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             shift_q, shift_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             busy_q, busy_d;

    dir_t             key_dir;
    logic             any_key;
    logic             multi_key;
    logic             press_evt;
    logic [LEN_W-1:0] clamped_len;

`ifdef PRESS_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_W-1:0] timer_q, timer_d;
`endif

    key_encoder u_key_encoder (
        .key       (key),
        .dir       (key_dir),
        .any_key   (any_key),
        .multi_key (multi_key)
    );

    assign press_evt   = any_key && (key_prev_q == 4'b0000);
    assign clamped_len = (round_len > LEN_W'(SEQ_LEN)) ? LEN_W'(SEQ_LEN) : round_len;

    always_comb begin
        state_d    = state_q;
        key_prev_d = key;
        match_d    = match_q;
        len_d      = len_q;
`ifdef PRESS_TIMEOUT_EN
        timer_d    = timer_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = clamped_len;
                    match_d = '0;
                    state_d = (clamped_len == '0) ? ST_PASS : ST_WAIT_PRESS;
`ifdef PRESS_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            ST_WAIT_PRESS: begin
                if (press_evt) begin
                    if (!multi_key && (key_dir == dir_t'(correct_direction))) begin
                        state_d = ST_SHIFT;
                        match_d = match_q + LEN_W'(1);
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
`ifdef PRESS_TIMEOUT_EN
                else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_FAIL;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`endif
            end
            ST_SHIFT:        state_d = ST_WAIT_RELEASE;
            ST_WAIT_RELEASE: begin
                if (key == 4'b0000) begin
                    state_d = (match_q == len_q) ? ST_PASS : ST_WAIT_PRESS;
`ifdef PRESS_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            ST_PASS:         state_d = ST_IDLE;
            ST_FAIL:         state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase

        // Outputs are registered alongside the state so they line up with it exactly.
        shift_d = (state_d == ST_SHIFT);
        pass_d  = (state_d == ST_PASS);
        fail_d  = (state_d == ST_FAIL);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            key_prev_q <= 4'b0000;
            match_q    <= '0;
            len_q      <= '0;
            shift_q    <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef PRESS_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            key_prev_q <= key_prev_d;
            match_q    <= match_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            busy_q     <= busy_d;
`ifdef PRESS_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

    assign shift_enable = shift_q;
    assign match_count  = match_q;
    assign busy         = busy_q;
    assign round_pass   = pass_q;
    assign round_fail   = fail_q;

endmodule

// File: tb/tb_press_checker.sv
// Directed, table-driven bench for press_checker; timeout checks follow PRESS_TIMEOUT_EN.
module tb_press_checker;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] round_len;
    logic [3:0] key;
    logic [1:0] correct_direction;
    logic       shift_enable;
    logic [1:0] match_count;
    logic       busy;
    logic       round_pass;
    logic       round_fail;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       start;
        logic [1:0] len;
        logic [3:0] key;
        logic [1:0] corr;
        logic       shift;
        logic       pass;
        logic       fail;
        logic       busy;
        logic [1:0] match;
    } vec_t;

    vec_t vecs[20];

    always #5 clock = ~clock;

    press_checker #(
        .SEQ_LEN (3),
        .LEN_W   (2)
`ifdef PRESS_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .round_len         (round_len),
        .key               (key),
        .correct_direction (correct_direction),
        .shift_enable      (shift_enable),
        .match_count       (match_count),
        .busy              (busy),
        .round_pass        (round_pass),
        .round_fail        (round_fail)
    );

    task automatic applyStimulus(input logic st, input logic [1:0] len,
                                 input logic [3:0] k, input logic [1:0] corr);
        start             = st;
        round_len         = len;
        key               = k;
        correct_direction = corr;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic sh, input logic ps,
                            input logic fl, input logic bz, input logic [1:0] mc);
        checkOutput({tag, ".shift_enable"}, int'(shift_enable), int'(sh));
        checkOutput({tag, ".round_pass"},   int'(round_pass),   int'(ps));
        checkOutput({tag, ".round_fail"},   int'(round_fail),   int'(fl));
        checkOutput({tag, ".busy"},         int'(busy),         int'(bz));
        checkOutput({tag, ".match_count"},  int'(match_count),  int'(mc));
    endtask

    initial begin
        int shifts;
        int passes;
        int fails;
        int n;

        //            start len    key      corr   shift pass fail busy match
        vecs[0]  = '{1'b1, 2'd3, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[1]  = '{1'b0, 2'd3, 4'b0001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[2]  = '{1'b0, 2'd3, 4'b0001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[3]  = '{1'b0, 2'd3, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[4]  = '{1'b0, 2'd3, 4'b0010, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
        vecs[5]  = '{1'b0, 2'd3, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
        vecs[6]  = '{1'b0, 2'd3, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
        vecs[7]  = '{1'b0, 2'd3, 4'b0100, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3};
        vecs[8]  = '{1'b0, 2'd3, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3};
        vecs[9]  = '{1'b0, 2'd3, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3};
        vecs[10] = '{1'b0, 2'd3, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3};
        vecs[11] = '{1'b1, 2'd3, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[12] = '{1'b0, 2'd3, 4'b1000, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
        vecs[13] = '{1'b0, 2'd3, 4'b1000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[14] = '{1'b0, 2'd3, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[15] = '{1'b1, 2'd2, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[16] = '{1'b0, 2'd2, 4'b0011, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
        vecs[17] = '{1'b0, 2'd2, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[18] = '{1'b1, 2'd0, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
        vecs[19] = '{1'b0, 2'd0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

        reset = 1'b1;
        applyStimulus(1'b0, 2'd0, 4'b0000, 2'b00);
        repeat (3) tick();
        checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
        tick();

        $display("[TB] table vectors");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].start, vecs[i].len, vecs[i].key, vecs[i].corr);
            tick();
            checkAll($sformatf("vec%0d", i), vecs[i].shift, vecs[i].pass,
                     vecs[i].fail, vecs[i].busy, vecs[i].match);
        end

        $display("[TB] held keys and start while busy");
        applyStimulus(1'b1, 2'd2, 4'b0001, 2'b00);
        tick();
        checkOutput("held_start.busy", int'(busy), 1);
        applyStimulus(1'b0, 2'd2, 4'b0001, 2'b00);
        shifts = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            shifts += int'(shift_enable);
        end
        checkOutput("held_start.no_shift", shifts, 0);
        applyStimulus(1'b0, 2'd2, 4'b0000, 2'b00);
        tick();
        applyStimulus(1'b0, 2'd2, 4'b0001, 2'b00);
        shifts = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            shifts += int'(shift_enable);
        end
        checkOutput("held20.shift_count", shifts, 1);
        checkOutput("held20.match_count", int'(match_count), 1);
        applyStimulus(1'b1, 2'd1, 4'b0001, 2'b01);
        tick();
        applyStimulus(1'b0, 2'd1, 4'b0000, 2'b01);
        tick();
        checkOutput("busy_start.no_pass", int'(round_pass), 0);
        checkOutput("busy_start.busy", int'(busy), 1);
        applyStimulus(1'b0, 2'd1, 4'b0010, 2'b01);
        tick();
        checkOutput("busy_start.shift", int'(shift_enable), 1);
        applyStimulus(1'b0, 2'd1, 4'b0000, 2'b01);
        tick();
        tick();
        checkOutput("busy_start.pass", int'(round_pass), 1);
        checkOutput("busy_start.match", int'(match_count), 2);
        tick();
        checkOutput("busy_start.idle", int'(busy), 0);

        $display("[TB] reset mid-round");
        applyStimulus(1'b1, 2'd3, 4'b0000, 2'b00);
        tick();
        applyStimulus(1'b0, 2'd3, 4'b0001, 2'b00);
        tick();
        tick();
        checkOutput("midreset.pre_match", int'(match_count), 1);
        reset = 1'b1;
        tick();
        checkAll("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 2'd3, 4'b0000, 2'b00);
        passes = 0;
        fails  = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            passes += int'(round_pass);
            fails  += int'(round_fail);
        end
        checkOutput("midreset.no_pass", passes, 0);
        checkOutput("midreset.no_fail", fails, 0);

        $display("[TB] press timeout");
        applyStimulus(1'b1, 2'd1, 4'b0000, 2'b00);
        tick();
        applyStimulus(1'b0, 2'd1, 4'b0000, 2'b00);
        n     = 0;
        fails = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (round_fail) begin
                fails = 1;
                break;
            end
        end
`ifdef PRESS_TIMEOUT_EN
        checkOutput("timeout.fired", fails, 1);
        checkOutput("timeout.cycles", n, 8);
`else
        checkOutput("no_timeout.fail", fails, 0);
        checkOutput("no_timeout.busy", int'(busy), 1);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
